fighter_action_input: RTL and testbench
=======================================

Name: fighter_action_input

Overview:
- Input-side producer for the two-player fighting game: turns raw push-buttons into the `action1`/`action2`/`actionEnable` interface that the game top consumes.
- Synchronises and debounces ten buttons (five per player) and encodes each player's first press into a 3-bit action code.
- Collects one commit per player per round, then presents both codes with a widened `actionEnable` strobe so the slower game clock samples it reliably.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a synchronised button must differ from its stable value before the stable value flips.
- ROUND_TIMEOUT, 50000000: clk cycles spent in COLLECT before firing with whatever has been committed.
- ENABLE_HOLD, 2500000: clk cycles `actionEnable` stays high. Must exceed one game-clock period.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn1  in  5  player-1 raw buttons, asynchronous, active-high
- btn2  in  5  player-2 raw buttons, asynchronous, active-high
- game_over  in  1  high = game finished; suppress all rounds
- action1  out  3  player-1 action code, stable between fires
- action2  out  3  player-2 action code, stable between fires
- actionEnable  out  1  high for ENABLE_HOLD cycles per round
- committed1  out  1  player 1 has locked an action this round (LED)
- committed2  out  1  player 2 has locked an action this round (LED)

Behaviour:
- Reset (one clk edge with reset=1) clears all of the following:
  - action1 = action2 = 3'b000; actionEnable = 0; committed1/2 = 0; state = IDLE.
  - Synchroniser flops and stable button values = 0; all counters = 0.
- Action code map, per player: btn[0]→001 forward, btn[1]→010 back, btn[2]→011 attack, btn[3]→100 block, btn[4]→101 special.
  - 000 = no action. 110 and 111 are never produced.
- Synchronisation: each raw bit passes through 2 flops.
- Debounce, per bit: counter increments while the synced value ≠ stable and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, stable ← synced and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change stable.
- Press event: one-cycle pulse on a 0→1 transition of a stable bit. Releases generate no event.
- Priority: several press events for one player in the same cycle → lowest index wins.
- Commit rules:
  - A press event while committedN=0, state ∈ {IDLE, COLLECT} and game_over=0 registers codeN and sets committedN.
  - Latency: exactly DEBOUNCE_CYCLES+3 clk cycles from the raw rising edge to committedN=1, for a clean press.
  - Events while committedN=1, in FIRE, or with game_over=1 are discarded. No re-commit or override within a round.
- FSM:
  - IDLE: any commit → COLLECT, timer=0. Both players commit in the same cycle → FIRE directly.
  - COLLECT: timer increments each cycle.
    - Both committed → FIRE.
    - timer == ROUND_TIMEOUT-1 → FIRE.
    - Both conditions in the same cycle → FIRE once.
  - FIRE entry edge: actionN ← codeN if committedN, else 000; actionEnable ← 1; hold counter=0.
  - FIRE: after ENABLE_HOLD cycles high, on the same edge:
    - actionEnable ← 0, committed1/2 ← 0, state ← IDLE.
    - action1/2 keep their values until the next FIRE entry.
- game_over=1, any state, on the next edge:
  - state ← IDLE; committed1/2 ← 0; actionEnable ← 0; timers cleared; action1/2 held.
  - A FIRE in progress is truncated.
- Reset mid-round: same as the reset values above; no partial fire is ever emitted.
- A button held across the end of FIRE does not re-commit. It must be released, debounced low, then pressed again.
- Counter widths: $clog2(param)+1 bits. Counters never wrap (they stop at the terminal count).

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, ROUND_TIMEOUT=16, ENABLE_HOLD=3.
1. Reset, then hold btn1[2] high 10 cycles and btn2[3] high 10 cycles, same start cycle → committed1/2 rise at cycle 7. FIRE: action1=011, action2=100, actionEnable high exactly 3 cycles, then committed1/2=0.
2. btn1[0] pulsed high 3 cycles (< debounce) → no commit, state stays IDLE, actionEnable never rises.
3. Only btn2[4] pressed → COLLECT. After 16 cycles: FIRE with action1=000, action2=101, actionEnable high 3 cycles.
4. btn1[1] and btn1[3] rise together, then btn1[4] pressed later in the same round; then btn2[0] → action1=010 (lowest index, later press ignored), action2=001.
5. game_over asserted on the 2nd cycle of FIRE → actionEnable=0 next edge, committed cleared. Presses during game_over produce no commit. action1/2 keep their fired values.
6. reset asserted in COLLECT with committed1=1 → next edge: all outputs 000/0, state IDLE. No actionEnable pulse afterwards without new presses.

Source files
------------

// File: rtl/fighter_action_if.sv
// Button/action bundle between the raw-input side and the action producer.
//   btn1, btn2   : raw player buttons (5 each), asynchronous, active-high
//   game_over    : high suppresses all rounds
//   action1/2    : 3-bit action codes, stable between fires
//   actionEnable : widened strobe telling the game top to sample action1/2
//   committed1/2 : per-player "action locked this round" indicators
// master = the side that owns the buttons and consumes the actions.
// slave  = fighter_action_input.
interface fighter_action_if;
  logic [4:0] btn1;
  logic [4:0] btn2;
  logic       game_over;
  logic [2:0] action1;
  logic [2:0] action2;
  logic       actionEnable;
  logic       committed1;
  logic       committed2;

  modport master (
    output btn1, btn2, game_over,
    input  action1, action2, actionEnable, committed1, committed2
  );

  modport slave (
    input  btn1, btn2, game_over,
    output action1, action2, actionEnable, committed1, committed2
  );
endinterface

// File: rtl/fighter_action_input.sv
// Turns ten raw push-buttons into one action code per player per round.
// Each button is synchronised (2 flops) and debounced; the first press of
// each player in a round is encoded and locked. When both players have
// committed, or the round times out, both codes are presented together with
// an actionEnable strobe held long enough for the slower game clock.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : fighter_action_if.slave (buttons and game_over in, actions out)
module fighter_action_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ROUND_TIMEOUT   = 50000000,
  parameter int ENABLE_HOLD     = 2500000
) (
  input  logic                   clk,
  input  logic                   reset,
  fighter_action_if.slave        bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMR_W  = $clog2(ROUND_TIMEOUT) + 1;
  localparam int HOLD_W = $clog2(ENABLE_HOLD) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ROUND_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ENABLE_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FIRE
  } state_e;

  // ---------------------------------------------------------------------
  // Synchronise and debounce. Bits [4:0] are player 1, [9:5] player 2.
  // ---------------------------------------------------------------------
  logic [9:0]      sync0_q, sync1_q;
  logic [9:0]      stable_q, stable_prev_q;
  logic [DB_W-1:0] db_cnt_q [10];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (the sync chain relies on it).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q       <= '0;
      sync1_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      // NOTE: this array is ten small counters built from flops, not a RAM,
      // so clearing it on reset is cheap and keeps debounce deterministic.
      for (int i = 0; i < 10; i++) db_cnt_q[i] <= '0;
    end else begin
      sync0_q       <= {bus.btn2, bus.btn1};
      sync1_q       <= sync0_q;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 10; i++) begin
        if (sync1_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          // DEBOUNCE_CYCLES consecutive disagreeing samples: accept the change.
          stable_q[i] <= sync1_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle press pulses on stable 0->1; releases are ignored.
  logic [9:0] press;
  assign press = stable_q & ~stable_prev_q;

  // Lowest index wins when several buttons rise together.
  function automatic logic [2:0] encode(input logic [4:0] p);
    logic [2:0] code;
    code = 3'b000;
    if      (p[0]) code = 3'b001;
    else if (p[1]) code = 3'b010;
    else if (p[2]) code = 3'b011;
    else if (p[3]) code = 3'b100;
    else if (p[4]) code = 3'b101;
    return code;
  endfunction

  // ---------------------------------------------------------------------
  // Commit logic and round FSM.
  // ---------------------------------------------------------------------
  state_e             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [2:0]         code1_q, code2_q;
  logic [2:0]         code1_d, code2_d;
  logic               committed1_q, committed2_q;
  logic               committed1_d, committed2_d;
  logic [2:0]         action1_q, action2_q;
  logic               enable_q;
  logic               can_commit, commit1, commit2;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    can_commit   = 1'b0;
    commit1      = 1'b0;
    commit2      = 1'b0;
    committed1_d = committed1_q;
    committed2_d = committed2_q;
    code1_d      = code1_q;
    code2_d      = code2_q;

    can_commit = !bus.game_over && (state_q == S_IDLE || state_q == S_COLLECT);
    commit1    = can_commit && !committed1_q && (|press[4:0]);
    commit2    = can_commit && !committed2_q && (|press[9:5]);

    if (commit1) begin
      committed1_d = 1'b1;
      code1_d      = encode(press[4:0]);
    end
    if (commit2) begin
      committed2_d = 1'b1;
      code2_d      = encode(press[9:5]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      hold_q       <= '0;
      code1_q      <= '0;
      code2_q      <= '0;
      committed1_q <= 1'b0;
      committed2_q <= 1'b0;
      action1_q    <= '0;
      action2_q    <= '0;
      enable_q     <= 1'b0;
    end else if (bus.game_over) begin
      // Abort whatever round is running; the last fired codes stay visible.
      state_q      <= S_IDLE;
      timer_q      <= '0;
      hold_q       <= '0;
      committed1_q <= 1'b0;
      committed2_q <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      committed1_q <= committed1_d;
      committed2_q <= committed2_d;
      code1_q      <= code1_d;
      code2_q      <= code2_d;

      unique case (state_q)
        S_IDLE: begin
          if (committed1_d && committed2_d) begin
            state_q   <= S_FIRE;
            action1_q <= code1_d;
            action2_q <= code2_d;
            enable_q  <= 1'b1;
            hold_q    <= '0;
          end else if (commit1 || commit2) begin
            state_q <= S_COLLECT;
            timer_q <= '0;
          end
        end

        S_COLLECT: begin
          // Fire on the very edge the second commit lands, or at timeout;
          // both at once still gives a single fire.
          if ((committed1_d && committed2_d) || timer_q == TMR_LAST) begin
            state_q   <= S_FIRE;
            action1_q <= committed1_d ? code1_d : 3'b000;
            action2_q <= committed2_d ? code2_d : 3'b000;
            enable_q  <= 1'b1;
            hold_q    <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_FIRE: begin
          if (hold_q == HOLD_LAST) begin
            state_q      <= S_IDLE;
            enable_q     <= 1'b0;
            committed1_q <= 1'b0;
            committed2_q <= 1'b0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.action1      = action1_q;
  assign bus.action2      = action2_q;
  assign bus.actionEnable = enable_q;
  assign bus.committed1   = committed1_q;
  assign bus.committed2   = committed2_q;

endmodule

// File: tb/tb_fighter_action_input.sv
// Directed bench for fighter_action_input with small timing parameters.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven
// at the same point so they are stable well before the next edge.
module tb_fighter_action_input;

  localparam int DB = 4;
  localparam int RT = 16;
  localparam int EH = 3;

  logic clk = 1'b0;
  logic reset;

  fighter_action_if bus();

  fighter_action_input #(
    .DEBOUNCE_CYCLES(DB),
    .ROUND_TIMEOUT  (RT),
    .ENABLE_HOLD    (EH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0] b1;
    logic [4:0] b2;
    logic       go;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [20];

  // Output bundle: {action1, action2, actionEnable, committed1, committed2}
  function automatic logic [8:0] outs();
    return {bus.action1, bus.action2, bus.actionEnable, bus.committed1, bus.committed2};
  endfunction

  function automatic logic [8:0] e(input logic [2:0] a1, input logic [2:0] a2,
                                   input logic en, input logic c1, input logic c2);
    return {a1, a2, en, c1, c2};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got a1=%b a2=%b en=%b c1=%b c2=%b, want a1=%b a2=%b en=%b c1=%b c2=%b",
               name, act[8:6], act[5:3], act[2], act[1], act[0],
               exp[8:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1 table: both players press on the same cycle, row i is edge i+1.
    for (int i = 0; i < 20; i++) begin
      vecs[i].b1 = (i < 10) ? 5'b00100 : 5'b00000;
      vecs[i].b2 = (i < 10) ? 5'b01000 : 5'b00000;
      vecs[i].go = 1'b0;
      if (i < 6)      vecs[i].exp = e(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      else if (i < 9) vecs[i].exp = e(3'b011, 3'b100, 1'b1, 1'b1, 1'b1);
      else            vecs[i].exp = e(3'b011, 3'b100, 1'b0, 1'b0, 1'b0);
    end

    reset         = 1'b1;
    bus.btn1      = '0;
    bus.btn2      = '0;
    bus.game_over = 1'b0;
    step();
    step();
    check("reset_state", outs(), e(3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;

    // 1. Simultaneous attack / block, fire directly from IDLE.
    for (int i = 0; i < 20; i++) begin
      bus.btn1      = vecs[i].b1;
      bus.btn2      = vecs[i].b2;
      bus.game_over = vecs[i].go;
      step();
      check($sformatf("s1_row%0d", i), outs(), vecs[i].exp);
    end

    // 2. Three-cycle glitch never debounces, nothing fires.
    bus.btn1 = 5'b00001;
    repeat (3) step();
    bus.btn1 = 5'b00000;
    for (int i = 0; i < 25; i++) begin
      step();
      check($sformatf("s2_glitch%0d", i), outs(), e(3'b011, 3'b100, 1'b0, 1'b0, 1'b0));
    end

    // 3. Only player 2 presses special; round times out.
    bus.btn2 = 5'b10000;
    repeat (6) step();
    check("s3_edge6", outs(), e(3'b011, 3'b100, 1'b0, 1'b0, 1'b0));
    step();
    check("s3_commit", outs(), e(3'b011, 3'b100, 1'b0, 1'b0, 1'b1));
    bus.btn2 = 5'b00000;
    repeat (15) step();
    check("s3_pre_timeout", outs(), e(3'b011, 3'b100, 1'b0, 1'b0, 1'b1));
    step();
    check("s3_fire", outs(), e(3'b000, 3'b101, 1'b1, 1'b0, 1'b1));
    repeat (2) step();
    check("s3_hold_last", outs(), e(3'b000, 3'b101, 1'b1, 1'b0, 1'b1));
    step();
    check("s3_end", outs(), e(3'b000, 3'b101, 1'b0, 1'b0, 1'b0));
    repeat (10) step();

    // 4. Priority (back beats block), later press ignored, then player 2.
    bus.btn1 = 5'b01010;
    repeat (7) step();
    check("s4_commit1", outs(), e(3'b000, 3'b101, 1'b0, 1'b1, 1'b0));
    bus.btn1 = 5'b11010;
    repeat (7) step();
    check("s4_late_press", outs(), e(3'b000, 3'b101, 1'b0, 1'b1, 1'b0));
    bus.btn1 = 5'b00000;
    bus.btn2 = 5'b00001;
    repeat (6) step();
    check("s4_pre_commit2", outs(), e(3'b000, 3'b101, 1'b0, 1'b1, 1'b0));
    step();
    check("s4_fire", outs(), e(3'b010, 3'b001, 1'b1, 1'b1, 1'b1));
    bus.btn2 = 5'b00000;
    repeat (2) step();
    check("s4_hold_last", outs(), e(3'b010, 3'b001, 1'b1, 1'b1, 1'b1));
    step();
    check("s4_end", outs(), e(3'b010, 3'b001, 1'b0, 1'b0, 1'b0));
    repeat (10) step();

    // 5. game_over truncates a fire and blocks later presses.
    bus.btn1 = 5'b00001;
    bus.btn2 = 5'b00100;
    repeat (7) step();
    check("s5_fire", outs(), e(3'b001, 3'b011, 1'b1, 1'b1, 1'b1));
    step();
    check("s5_fire_cyc2", outs(), e(3'b001, 3'b011, 1'b1, 1'b1, 1'b1));
    bus.game_over = 1'b1;
    step();
    check("s5_truncated", outs(), e(3'b001, 3'b011, 1'b0, 1'b0, 1'b0));
    bus.btn1 = 5'b00000;
    bus.btn2 = 5'b00000;
    repeat (10) step();
    bus.btn1 = 5'b00010;
    bus.btn2 = 5'b10000;
    repeat (10) step();
    check("s5_press_in_go", outs(), e(3'b001, 3'b011, 1'b0, 1'b0, 1'b0));
    bus.btn1 = 5'b00000;
    bus.btn2 = 5'b00000;
    repeat (10) step();
    bus.game_over = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("s5_after_go%0d", i), outs(), e(3'b001, 3'b011, 1'b0, 1'b0, 1'b0));
    end

    // 6. Reset in COLLECT with player 1 committed.
    bus.btn1 = 5'b00100;
    repeat (7) step();
    check("s6_collect", outs(), e(3'b001, 3'b011, 1'b0, 1'b1, 1'b0));
    repeat (3) step();
    reset    = 1'b1;
    bus.btn1 = 5'b00000;
    step();
    check("s6_reset", outs(), e(3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      check($sformatf("s6_quiet%0d", i), outs(), e(3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
